// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master round-robin arbiter in front of one word-addressed
// memory port. A granted request is latched into the s_* registers and held
// until the slave completes it.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a slave-response watchdog
// and the m_err completion-with-error strobe.

// Per-master request decode: any strobe is a request, write wins over read.
module mem_arb_lane (
  input  logic rd,
  input  logic wr,
  output logic req,
  output logic is_wr
);
  assign req   = rd | wr;
  assign is_wr = wr;
endmodule

module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int BSEL_W      = DATA_W / 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dataD,
  input  logic [NUM_MASTERS*BSEL_W-1:0] m_byteSel,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  output logic [DATA_W-1:0]             m_dataQ,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_dataD,
  output logic [BSEL_W-1:0]             s_byteSel,
  output logic                          s_read,
  output logic                          s_write,
  input  logic [DATA_W-1:0]             s_dataQ,
  input  logic                          s_ready
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic [NUM_MASTERS-1:0]        m_err
`endif
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  // Reject configurations the datapath slicing cannot support.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (DATA_W % 8) != 0 ||
      BSEL_W != DATA_W / 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mem_bus_arbiter: unsupported parameter set");
  end

  // Per-master views of the packed request buses.
  logic [NUM_MASTERS-1:0] req, is_wr;
  logic [ADDR_W-1:0]      addr_a [NUM_MASTERS];
  logic [DATA_W-1:0]      data_a [NUM_MASTERS];
  logic [BSEL_W-1:0]      bsel_a [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    mem_arb_lane u_lane (
      .rd    (m_read[i]),
      .wr    (m_write[i]),
      .req   (req[i]),
      .is_wr (is_wr[i])
    );
    assign addr_a[i] = m_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = m_dataD[i*DATA_W +: DATA_W];
    assign bsel_a[i] = m_byteSel[i*BSEL_W +: BSEL_W];
  end

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [GW-1:0]     g_q, g_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_dataD_q, s_dataD_d;
  logic [BSEL_W-1:0] s_byteSel_q, s_byteSel_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;

  // Round-robin pick: first requester after the last-served master, wrapping.
  logic          found;
  logic [GW-1:0] pick, cand;
  int            idx;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx  = (int'(rr_q) + k) % NUM_MASTERS;
      cand = GW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Completion conditions for the transaction in flight.
  logic busy, done_ok, done_to;
  assign busy    = (state_q == BUSY);
  assign done_ok = busy && s_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Watchdog fires only if the slave is still silent at the limit.
  assign done_to = busy && !s_ready && (cnt_q == CNT_W'(TIMEOUT));
`else
  assign done_to = 1'b0;
`endif

  // Next-state and latch computation for the two-state grant FSM.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    g_d         = g_q;
    s_addr_d    = s_addr_q;
    s_dataD_d   = s_dataD_q;
    s_byteSel_d = s_byteSel_q;
    s_read_d    = s_read_q;
    s_write_d   = s_write_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
        if (found) begin
          s_addr_d    = addr_a[pick];
          s_dataD_d   = data_a[pick];
          s_byteSel_d = bsel_a[pick];
          s_write_d   = is_wr[pick];
          s_read_d    = !is_wr[pick];
          g_d         = pick;
          rr_d        = pick;
          state_d     = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (done_ok || done_to) begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          state_d   = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered slave-side outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= GW'(NUM_MASTERS - 1);
      g_q         <= '0;
      s_addr_q    <= '0;
      s_dataD_q   <= '0;
      s_byteSel_q <= '0;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      g_q         <= g_d;
      s_addr_q    <= s_addr_d;
      s_dataD_q   <= s_dataD_d;
      s_byteSel_q <= s_byteSel_d;
      s_read_q    <= s_read_d;
      s_write_q   <= s_write_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_addr    = s_addr_q;
  assign s_dataD   = s_dataD_q;
  assign s_byteSel = s_byteSel_q;
  assign s_read    = s_read_q;
  assign s_write   = s_write_q;

  // Master-side strobes are combinational so ready lands in the slave's cycle;
  // a reset cycle suppresses them so an aborted request never completes.
  always_comb begin
    m_ready = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ready[i] = !rst && (done_ok || done_to) && (g_q == GW'(i));
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Error strobe and zeroed read data mark a watchdog completion.
  always_comb begin
    m_err = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_err[i] = !rst && done_to && (g_q == GW'(i));
    end
  end
  assign m_dataQ = done_to ? '0 : s_dataQ;
`else
  assign m_dataQ = s_dataQ;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps from the test plan, then a
// randomized phase checked against a transaction-level arbitration model.
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_dataD;
  logic [N*BW-1:0] m_byteSel;
  logic [N-1:0]    m_read, m_write;
  logic [DW-1:0]   m_dataQ;
  logic [N-1:0]    m_ready;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_dataD;
  logic [BW-1:0]   s_byteSel;
  logic            s_read, s_write;
  logic [DW-1:0]   s_dataQ;
  logic            s_ready;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [N-1:0]    m_err;
`endif

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_dataD(m_dataD), .m_byteSel(m_byteSel),
    .m_read(m_read), .m_write(m_write),
    .m_dataQ(m_dataQ), .m_ready(m_ready),
    .s_addr(s_addr), .s_dataD(s_dataD), .s_byteSel(s_byteSel),
    .s_read(s_read), .s_write(s_write),
    .s_dataQ(s_dataQ), .s_ready(s_ready)
`ifdef MEM_ARB_TIMEOUT_EN
    , .m_err(m_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    m_read[i]            = rd;
    m_write[i]           = wr;
    m_addr[i*AW +: AW]   = a;
    m_dataD[i*DW +: DW]  = d;
    m_byteSel[i*BW +: BW] = b;
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model state (transaction level).
  logic          act [N];
  logic          twr [N];
  logic [AW-1:0] ta  [N];
  logic [DW-1:0] td  [N];
  logic [BW-1:0] tb_ [N];
  logic          mbusy, mwr, found, to, done;
  int            mg, mlast, mcnt, dropped, ii;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic [BW-1:0] mbsel;
  logic [N-1:0]  exp_rdy, rdy_seen;
  logic [1:0]    op;

  initial begin
    rst = 1'b1;
    m_addr = '0; m_dataD = '0; m_byteSel = '0; m_read = '0; m_write = '0;
    s_dataQ = '0; s_ready = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_dataD", s_dataD, 0);
    chk("rst_s_byteSel", s_byteSel, 0);
    nxt();
    rst = 1'b0;

    // Single read with three slave wait cycles.
    set_m(0, 1, 0, 30'h100, 32'h0, 4'hF);
    @(negedge clk); chk("rd_idle_s_read", s_read, 0);
    nxt();
    @(negedge clk); chk("rd_strobe", s_read, 1); chk("rd_addr", s_addr, 30'h100); chk("rd_w1_ready", m_ready, 0);
    nxt(); @(negedge clk); chk("rd_w2_ready", m_ready, 0);
    nxt(); @(negedge clk); chk("rd_w3_ready", m_ready, 0);
    nxt(); s_ready = 1'b1; s_dataQ = 32'hDEADBEEF;
    @(negedge clk); chk("rd_ready", m_ready, 4'b0001); chk("rd_dataQ", m_dataQ, 32'hDEADBEEF);
    nxt(); set_m(0, 0, 0, 0, 0, 0); s_ready = 1'b0;
    @(negedge clk); chk("rd_after_s_read", s_read, 0); chk("rd_after_ready", m_ready, 0);

    // Write latching while the master changes its inputs mid-transaction.
    set_m(1, 0, 1, 30'h2A, 32'h12345678, 4'b0011);
    nxt();
    @(negedge clk);
    chk("wr_strobe", s_write, 1); chk("wr_no_read", s_read, 0);
    chk("wr_addr", s_addr, 30'h2A); chk("wr_data", s_dataD, 32'h12345678); chk("wr_bsel", s_byteSel, 4'b0011);
    set_m(1, 0, 1, 30'h3F, 32'hCAFEF00D, 4'b1100);
    nxt(); @(negedge clk);
    chk("wr_hold_addr", s_addr, 30'h2A); chk("wr_hold_data", s_dataD, 32'h12345678);
    chk("wr_hold_bsel", s_byteSel, 4'b0011); chk("wr_hold_ready", m_ready, 0);
    nxt(); s_ready = 1'b1;
    @(negedge clk); chk("wr_ready", m_ready, 4'b0010); chk("wr_ready_addr", s_addr, 30'h2A);
    nxt(); set_m(1, 0, 0, 0, 0, 0); s_ready = 1'b0;
    @(negedge clk); chk("wr_after", s_write, 0);

    // Read and write together resolve to a write.
    set_m(0, 1, 1, 30'h7, 32'hA5A5A5A5, 4'hF);
    nxt(); s_ready = 1'b1;
    @(negedge clk); chk("rw_write", s_write, 1); chk("rw_read", s_read, 0); chk("rw_ready", m_ready, 4'b0001);
    nxt(); set_m(0, 0, 0, 0, 0, 0); s_ready = 1'b0;
    @(negedge clk); chk("rw_after", s_write, 0);

    // Reset while waiting on the slave; master 0 was last served before it.
    set_m(0, 1, 0, 30'h55, 0, 4'hF);
    nxt(); @(negedge clk); chk("rb_strobe", s_read, 1);
    nxt(); rst = 1'b1; set_m(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rb_rst_ready", m_ready, 0);
    nxt(); rst = 1'b0; s_ready = 1'b1;
    set_m(0, 1, 0, 30'h10, 0, 4'hF); set_m(1, 1, 0, 30'h11, 0, 4'hF);
    @(negedge clk); chk("rb_idle_read", s_read, 0); chk("rb_idle_write", s_write, 0); chk("rb_idle_ready", m_ready, 0);
    nxt();
    @(negedge clk); chk("rb_grant0_read", s_read, 1); chk("rb_grant0_addr", s_addr, 30'h10); chk("rb_grant0_ready", m_ready, 4'b0001);
    nxt(); set_m(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rb_gap_ready", m_ready, 0);
    nxt();
    @(negedge clk); chk("rb_grant1_addr", s_addr, 30'h11); chk("rb_grant1_ready", m_ready, 4'b0010);
    nxt(); set_m(1, 0, 0, 0, 0, 0); s_ready = 1'b0;

    // Round-robin with all masters requesting and a zero-wait slave.
    rst = 1'b1; nxt(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_m(i, 1, 0, AW'(i), 0, 4'hF);
    s_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_rdy = (c % 2 == 1) ? N'(1 << ((c / 2) % N)) : '0;
      chk("rr_ready", m_ready, exp_rdy);
      if (c % 2 == 1) chk("rr_addr", s_addr, AW'((c / 2) % N));
      rdy_seen = m_ready;
      nxt();
      for (int i = 0; i < N; i++) m_read[i] = !rdy_seen[i];
    end
    m_read = '0; s_ready = 1'b0;
    nxt(); nxt();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: the slave never answers.
    set_m(1, 1, 0, 30'h77, 0, 4'hF);
    nxt(); s_dataQ = 32'h13579BDF;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_wait_err", m_err, 0); chk("to_wait_ready", m_ready, 0); chk("to_wait_read", s_read, 1);
      nxt();
    end
    @(negedge clk);
    chk("to_err", m_err, 4'b0010); chk("to_ready", m_ready, 4'b0010); chk("to_dataQ", m_dataQ, 0);
    nxt(); set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("to_after_read", s_read, 0); chk("to_after_err", m_err, 0);
    nxt();
`endif

    // Randomized traffic against the arbitration model.
    rst = 1'b1; m_read = '0; m_write = '0; s_ready = 1'b0; nxt(); rst = 1'b0;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    mbusy = 1'b0; mlast = N - 1; mg = 0; mcnt = 0; mwr = 1'b0;
    maddr = '0; mdata = '0; mbsel = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      to = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to = mbusy && !s_ready && (mcnt == TO);
`endif
      done = mbusy && (s_ready || to);
      exp_rdy = done ? N'(1 << mg) : '0;
      chk("rnd_ready", m_ready, exp_rdy);
      if (mbusy) begin
        chk("rnd_s_read", s_read, !mwr);
        chk("rnd_s_write", s_write, mwr);
        chk("rnd_s_addr", s_addr, maddr);
        chk("rnd_s_dataD", s_dataD, mdata);
        chk("rnd_s_bsel", s_byteSel, mbsel);
      end else begin
        chk("rnd_idle_strobes", {s_read, s_write}, 2'b00);
      end
      if (done) chk("rnd_dataQ", m_dataQ, to ? '0 : s_dataQ);
`ifdef MEM_ARB_TIMEOUT_EN
      chk("rnd_err", m_err, to ? N'(1 << mg) : '0);
`endif
      dropped = -1;
      if (!mbusy) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          ii = (mlast + k) % N;
          if (!found && act[ii]) begin
            found = 1'b1;
            mbusy = 1'b1; mg = ii; mlast = ii; mcnt = 0;
            mwr = twr[ii]; maddr = ta[ii]; mdata = td[ii]; mbsel = tb_[ii];
          end
        end
      end else if (done) begin
        mbusy = 1'b0;
        dropped = mg;
      end else begin
        mcnt++;
      end
      nxt();
      if (dropped >= 0) begin
        act[dropped] = 1'b0;
        set_m(dropped, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < N; i++) begin
        if (!act[i] && i != dropped && $urandom_range(0, 2) == 0) begin
          op     = 2'($urandom_range(1, 3));
          act[i] = 1'b1;
          twr[i] = op[1];
          ta[i]  = AW'($urandom);
          td[i]  = $urandom;
          tb_[i] = BW'($urandom);
          set_m(i, op[0], op[1], ta[i], td[i], tb_[i]);
        end
      end
      s_ready = mbusy ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
      s_dataQ = $urandom;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
